// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: splits fetch bundles into ordered instructions, classifies
// and issues them, halting on the all-zero word. Option: DECODE_STALL_COUNT_EN.
module decode_issue_ctrl #(
   parameter int INSTRUCTION_LENGTH = 32,
   parameter int BUS_WIDTH          = 2 * INSTRUCTION_LENGTH,
   parameter int TYPE_WIDTH         = 3,
   parameter int PC_WIDTH           = 64,
   parameter int COUNT_WIDTH        = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BUS_WIDTH-1:0]          in_data,
   input  logic [PC_WIDTH-1:0]           in_pc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [INSTRUCTION_LENGTH-1:0] out_instruction,
   output logic [PC_WIDTH-1:0]           out_pc,
   output logic [TYPE_WIDTH-1:0]         out_type,
   output logic                          halt,
   output logic [COUNT_WIDTH-1:0]        issued_count
`ifdef DECODE_STALL_COUNT_EN
   ,
   output logic [COUNT_WIDTH-1:0]        stall_count
`endif
);

   localparam int IL = INSTRUCTION_LENGTH;

   localparam logic [TYPE_WIDTH-1:0] R_TYPE       = TYPE_WIDTH'(0);
   localparam logic [TYPE_WIDTH-1:0] I_TYPE       = TYPE_WIDTH'(1);
   localparam logic [TYPE_WIDTH-1:0] S_TYPE       = TYPE_WIDTH'(2);
   localparam logic [TYPE_WIDTH-1:0] SB_TYPE      = TYPE_WIDTH'(3);
   localparam logic [TYPE_WIDTH-1:0] U_TYPE       = TYPE_WIDTH'(4);
   localparam logic [TYPE_WIDTH-1:0] UJ_TYPE      = TYPE_WIDTH'(5);
   localparam logic [TYPE_WIDTH-1:0] ILLEGAL_TYPE = '1;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      HALTED
   } state_t;

   state_t state_q, state_d;

   logic [IL-1:0]       hold_word_q;
   logic [PC_WIDTH-1:0] hold_pc_q;

   logic                accept;
   logic                fire;
   logic                load;
   logic                hold_en;
   logic                load_zero;
   logic                valid_d;
   logic [IL-1:0]       load_word;
   logic [PC_WIDTH-1:0] load_pc;

   function automatic logic [TYPE_WIDTH-1:0] classify(
      input logic [6:0] opcode
   );
      logic [TYPE_WIDTH-1:0] t;
      unique case (opcode)
         7'b0110011, 7'b0111011: t = R_TYPE;
         7'b0010011, 7'b0011011,
         7'b0000011, 7'b1100111,
         7'b1110011:             t = I_TYPE;
         7'b0100011:             t = S_TYPE;
         7'b1100011:             t = SB_TYPE;
         7'b0110111, 7'b0010111: t = U_TYPE;
         7'b1101111:             t = UJ_TYPE;
         default:                t = ILLEGAL_TYPE;
      endcase
      return t;
   endfunction

   assign in_ready = (state_q == IDLE)
                   | ((state_q == HIGH) & out_ready);
   assign accept   = in_valid & in_ready;
   assign fire     = out_valid & out_ready;

   always_comb begin
      state_d   = state_q;
      valid_d   = out_valid;
      load      = 1'b0;
      hold_en   = 1'b0;
      load_word = in_data[IL-1:0];
      load_pc   = in_pc;
      unique case (state_q)
         IDLE, HIGH: begin
            if (accept) begin
               load = 1'b1;
               if (!in_pc[2]) begin
                  hold_en = 1'b1;
                  state_d = LOW;
               end else begin
                  load_word = in_data[BUS_WIDTH-1:IL];
                  state_d   = HIGH;
               end
            end else if ((state_q == HIGH) && out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         LOW: begin
            if (out_ready) begin
               load      = 1'b1;
               load_word = hold_word_q;
               load_pc   = hold_pc_q;
               state_d   = HIGH;
            end
         end
         HALTED: begin
            valid_d = 1'b0;
         end
      endcase
      load_zero = load && (load_word == '0);
      // the end-of-program word is swallowed rather than issued
      if (load_zero) begin
         valid_d = 1'b0;
         state_d = HALTED;
      end else if (load) begin
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         out_valid       <= 1'b0;
         out_instruction <= '0;
         out_pc          <= '0;
         out_type        <= '0;
         hold_word_q     <= '0;
         hold_pc_q       <= '0;
         halt            <= 1'b0;
         issued_count    <= '0;
      end else begin
         state_q   <= state_d;
         out_valid <= valid_d;
         if (load && !load_zero) begin
            out_instruction <= load_word;
            out_pc          <= load_pc;
            out_type        <= classify(load_word[6:0]);
         end
         if (hold_en) begin
            hold_word_q <= in_data[BUS_WIDTH-1:IL];
            hold_pc_q   <= in_pc + PC_WIDTH'(4);
         end
         if (load_zero) begin
            halt <= 1'b1;
         end
         if (fire) begin
            issued_count <= issued_count + COUNT_WIDTH'(1);
         end
      end
   end

`ifdef DECODE_STALL_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (out_valid && !out_ready) begin
         stall_count <= stall_count + COUNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed plus random stimulus against a queue-based
// model of the instruction stream.
module tb_decode_issue_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_data = '0;
   logic [63:0] in_pc = '0;
   logic        in_ready;
   logic        out_valid;
   logic        halt;
   logic [31:0] out_instruction;
   logic [63:0] out_pc;
   logic [2:0]  out_type;
   logic [31:0] issued_count;
`ifdef DECODE_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif

   int n_chk = 0;
   int n_fail = 0;

   decode_issue_ctrl dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_pc(in_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instruction(out_instruction),
      .out_pc(out_pc),
      .out_type(out_type),
      .halt(halt),
      .issued_count(issued_count)
`ifdef DECODE_STALL_COUNT_EN
      ,
      .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   // opcode table and matching type codes
   logic [6:0] op_tab [12] = '{
      7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h67,
      7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f
   };
   int ty_tab [12] = '{0, 0, 1, 1, 1, 1, 1, 2, 3, 4, 4, 5};

   function automatic logic [2:0] ref_type(logic [31:0] w);
      logic [2:0] t = 3'd7;
      foreach (op_tab[i]) begin
         if (op_tab[i] == w[6:0]) t = 3'(ty_tab[i]);
      end
      return t;
   endfunction

   // model: queue of instructions still to be presented, in program order
   typedef struct {
      logic [31:0] w;
      logic [63:0] pc;
   } item_t;

   item_t       pend [$];
   item_t       it;
   bit          m_halt = 1'b0;
   int unsigned m_count = 0;
   int unsigned m_stall = 0;
   bit          m_v;
   bit          m_rdy;

   function automatic bit m_in_ready(logic ordy);
      return !m_halt && (pend.size() == 0 || (pend.size() == 1 && ordy));
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         pend.delete();
         m_halt  = 1'b0;
         m_count = 0;
         m_stall = 0;
      end else begin
         m_v   = pend.size() > 0;
         m_rdy = m_in_ready(out_ready);
         if (m_v && out_ready) begin
            void'(pend.pop_front());
            m_count++;
         end
         if (m_v && !out_ready) m_stall++;
         if (in_valid && m_rdy) begin
            if (!in_pc[2]) begin
               it.w  = in_data[31:0];
               it.pc = in_pc;
               pend.push_back(it);
               it.pc = in_pc + 64'd4;
            end else begin
               it.pc = in_pc;
            end
            it.w = in_data[63:32];
            pend.push_back(it);
         end
         if (pend.size() > 0 && pend[0].w == 32'd0) begin
            m_halt = 1'b1;
            pend.delete();
         end
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      bit v = pend.size() > 0;
      chk("out_valid", 64'(out_valid), 64'(v));
      if (v) begin
         chk("out_instruction", 64'(out_instruction), 64'(pend[0].w));
         chk("out_pc", out_pc, pend[0].pc);
         chk("out_type", 64'(out_type), 64'(ref_type(pend[0].w)));
      end
      chk("in_ready", 64'(in_ready), 64'(m_in_ready(out_ready)));
      chk("halt", 64'(halt), 64'(m_halt));
      chk("issued_count", 64'(issued_count), 64'(m_count));
`ifdef DECODE_STALL_COUNT_EN
      chk("stall_count", 64'(stall_count), 64'(m_stall));
`endif
   endtask

   task automatic step(bit rst, bit iv, logic [63:0] d,
                       logic [63:0] pc, bit ordy);
      @(negedge clk);
      reset     = rst;
      in_valid  = iv;
      in_data   = d;
      in_pc     = pc;
      out_ready = ordy;
      #1;
      cmp_model();
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w = $urandom;
      int s = $urandom_range(0, 99);
      if (s < 3) return 32'd0;
      if (s < 12) return w;
      w[6:0] = op_tab[$urandom_range(0, 11)];
      return w;
   endfunction

   function automatic logic [63:0] rand_pc();
      logic [63:0] p = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) p = '1;
      p[1:0] = 2'b00;
      return p;
   endfunction

   localparam logic [63:0] B1 = {32'h00a00093, 32'h002081b3};

   logic [63:0] pcs [$];
   int k;
   bit rr, iv, ordy;

   initial begin
      // reset state
      step(1, 0, '0, '0, 0);
      step(0, 0, '0, '0, 1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_count", 64'(issued_count), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // single bundle, two issues
      step(0, 1, B1, 64'h1000, 1);
      step(0, 0, '0, '0, 1);
      chk("b1_s0_instr", 64'(out_instruction), 64'h002081b3);
      chk("b1_s0_pc", out_pc, 64'h1000);
      chk("b1_s0_type", 64'(out_type), 64'd0);
      step(0, 0, '0, '0, 1);
      chk("b1_s1_instr", 64'(out_instruction), 64'h00a00093);
      chk("b1_s1_pc", out_pc, 64'h1004);
      chk("b1_s1_type", 64'(out_type), 64'd1);
      step(0, 0, '0, '0, 1);
      chk("b1_valid_after", 64'(out_valid), 64'd0);
      chk("b1_count", 64'(issued_count), 64'd2);

      // back-to-back bundles
      step(1, 0, '0, '0, 0);
      k = 0;
      for (int c = 0; c < 7; c++) begin
         step(0, 1, B1, 64'h1000 + 64'(8 * k), 1);
         chk("b2b_in_ready", 64'(in_ready), 64'(c % 2 == 0));
         if (out_valid) pcs.push_back(out_pc);
         if (m_in_ready(1'b1)) k++;
      end
      chk("b2b_pc0", pcs[0], 64'h1000);
      chk("b2b_pc1", pcs[1], 64'h1004);
      chk("b2b_pc2", pcs[2], 64'h1008);
      chk("b2b_pc3", pcs[3], 64'h100c);

      // stall with slot0 presented
      step(1, 0, '0, '0, 0);
      step(0, 1, B1, 64'h1000, 1);
      for (int c = 0; c < 3; c++) begin
         step(0, 0, '0, '0, 0);
         chk("stall_instr", 64'(out_instruction), 64'h002081b3);
         chk("stall_pc", out_pc, 64'h1000);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      step(0, 0, '0, '0, 1);
`ifdef DECODE_STALL_COUNT_EN
      chk("stall_count3", 64'(stall_count), 64'd3);
`endif

      // halt on zero slot1
      step(1, 0, '0, '0, 0);
      step(0, 1, {32'h0, 32'h00000013}, 64'h3000, 1);
      step(0, 0, '0, '0, 1);
      chk("halt_s0_instr", 64'(out_instruction), 64'h13);
      chk("halt_s0_type", 64'(out_type), 64'd1);
      step(0, 1, B1, 64'h3008, 1);
      chk("halt_valid", 64'(out_valid), 64'd0);
      chk("halt_flag", 64'(halt), 64'd1);
      for (int c = 0; c < 3; c++) begin
         step(0, 1, B1, 64'h3008, 1);
         chk("halt_in_ready", 64'(in_ready), 64'd0);
      end

      // odd start pc, then illegal opcode
      step(1, 0, '0, '0, 0);
      step(0, 1, {32'h0000006f, 32'h12345678}, 64'h2004, 1);
      step(0, 0, '0, '0, 1);
      chk("uj_instr", 64'(out_instruction), 64'h6f);
      chk("uj_pc", out_pc, 64'h2004);
      chk("uj_type", 64'(out_type), 64'd5);
      step(0, 1, {32'h00000013, 32'h0000007f}, 64'h2008, 1);
      chk("uj_single", 64'(out_valid), 64'd0);
      step(0, 0, '0, '0, 1);
      chk("ill_type", 64'(out_type), 64'd7);
      chk("ill_valid", 64'(out_valid), 64'd1);
      chk("ill_halt", 64'(halt), 64'd0);

      // reset in LOW
      step(1, 0, '0, '0, 0);
      step(0, 1, B1, 64'h1004, 1);
      step(0, 1, B1, 64'h1000, 1);
      step(0, 0, '0, '0, 0);
      chk("low_count", 64'(issued_count), 64'd1);
      step(1, 0, '0, '0, 1);
      step(0, 0, '0, '0, 1);
      chk("rlow_valid", 64'(out_valid), 64'd0);
      chk("rlow_count", 64'(issued_count), 64'd0);
      chk("rlow_halt", 64'(halt), 64'd0);
      chk("rlow_in_ready", 64'(in_ready), 64'd1);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         rr   = halt ? ($urandom_range(0, 9) == 0)
                     : ($urandom_range(0, 99) == 0);
         iv   = $urandom_range(0, 99) < 70;
         ordy = $urandom_range(0, 99) < 75;
         step(rr, iv, {rand_word(), rand_word()}, rand_pc(), ordy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
